dmx_pwm_dimmer: RTL and testbench

Eight-channel DMX512-driven PWM dimmer. A 250 kbaud DMX512 receiver decodes the serial line, and the first eight slots of each null-start-code packet set the duty cycles of eight 16-bit PWM outputs. The block sits between the board DMX input pin (after the RS-485 transceiver) and the active-high LED driver enables, and runs from the 48 MHz internal oscillator clock.

---
 rtl/dmx_pwm_dimmer.sv | 209 ++++++++++++++++++++
 tb/tb_dmx_pwm_dimmer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmx_pwm_dimmer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dmx_pwm_dimmer : DMX512 receiver driving eight 16-bit glitch-free PWM outputs
// Revision 1.0
// ============================================================================
module dmx_pwm_dimmer #(
  parameter int CLOCK_HZ     = 48000000,
  parameter int BIT_CLOCKS   = CLOCK_HZ / 250000,
  parameter int BREAK_CLOCKS = 22 * BIT_CLOCKS,
  parameter int BASE_CHANNEL = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dmx_in,
  output logic [7:0] pwm,
  output logic [7:0] data,
  output logic [8:0] channel,
  output logic       write_strobe
);

  localparam int                 BRK_W     = $clog2(BREAK_CLOCKS + 1);
  localparam int                 TMR_W     = $clog2(BIT_CLOCKS + 1);
  localparam logic [BRK_W-1:0]   BRK_MAX   = BRK_W'(BREAK_CLOCKS);
  localparam logic [BRK_W-1:0]   BRK_ARM   = BRK_W'(BREAK_CLOCKS - 1);
  localparam logic [TMR_W-1:0]   BIT_LAST  = TMR_W'(BIT_CLOCKS - 1);
  localparam logic [TMR_W-1:0]   HALF_LAST = TMR_W'(BIT_CLOCKS / 2 - 1);
  localparam logic [9:0]         SLOT_OVER = 10'd513;
  localparam logic [9:0]         BASE_LO   = 10'(BASE_CHANNEL);
  localparam logic [9:0]         BASE_HI   = 10'(BASE_CHANNEL + 7);

  typedef enum logic [2:0] {
    WAIT_BREAK = 3'd0,
    BREAK      = 3'd1,
    MAB        = 3'd2,
    START      = 3'd3,
    DATA       = 3'd4,
    STOP       = 3'd5,
    SKIP       = 3'd6
  } state_t;

  logic             sync_meta;
  logic             rx;
  logic [BRK_W-1:0] low_cnt;
  logic             break_hit;

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic [9:0]       slot, slot_n;
  logic [7:0]       data_n;
  logic [8:0]       channel_n;
  logic             strobe_n;

  logic [15:0]      pwm_cnt;
  logic             pwm_wrap;
  logic             in_range;
  logic [2:0]       wr_idx;

  // Line idles high, so the synchroniser resets to the mark level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b1;
      rx        <= 1'b1;
    end else begin
      sync_meta <= dmx_in;
      rx        <= sync_meta;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      low_cnt <= '0;
    end else if (rx) begin
      low_cnt <= '0;
    end else if (low_cnt != BRK_MAX) begin
      low_cnt <= low_cnt + BRK_W'(1);
    end
  end

  // True on the low clock that brings the run to BREAK_CLOCKS, and while it stays low.
  assign break_hit = !rx && (low_cnt >= BRK_ARM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= WAIT_BREAK;
      timer        <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      slot         <= '0;
      data         <= '0;
      channel      <= '0;
      write_strobe <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      bit_idx      <= bit_n;
      shift        <= shift_n;
      slot         <= slot_n;
      data         <= data_n;
      channel      <= channel_n;
      write_strobe <= strobe_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_n     = bit_idx;
    shift_n   = shift;
    slot_n    = slot;
    data_n    = data;
    channel_n = channel;
    strobe_n  = 1'b0;
    case (state)
      WAIT_BREAK, SKIP: begin
      end
      BREAK: begin
        slot_n = '0;
        if (rx) state_n = MAB;
      end
      // Also serves as the inter-slot mark: waits for the next start edge.
      MAB: begin
        if (!rx) begin
          state_n = START;
          timer_n = HALF_LAST;
        end
      end
      START: begin
        if (timer == '0) begin
          if (rx) begin
            state_n = WAIT_BREAK;
          end else begin
            state_n = DATA;
            timer_n = BIT_LAST;
            bit_n   = 3'd0;
          end
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      DATA: begin
        if (timer == '0) begin
          shift_n = {rx, shift[7:1]};
          timer_n = BIT_LAST;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      STOP: begin
        if (timer == '0) begin
          if (!rx) begin
            state_n = WAIT_BREAK;
          end else if (slot == 10'd0) begin
            slot_n  = 10'd1;
            state_n = (shift == 8'h00) ? MAB : SKIP;
          end else begin
            state_n = MAB;
            if (slot != SLOT_OVER) begin
              strobe_n  = 1'b1;
              data_n    = shift;
              channel_n = 9'(slot - 10'd1);
              slot_n    = slot + 10'd1;
            end
          end
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      default: state_n = WAIT_BREAK;
    endcase
    if (break_hit) state_n = BREAK;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 16'd1;
  end

  assign pwm_wrap = (pwm_cnt == 16'hFFFF);
  assign in_range = ({1'b0, channel} >= BASE_LO) && ({1'b0, channel} <= BASE_HI);
  assign wr_idx   = 3'(channel - 9'(BASE_CHANNEL));

  for (genvar n = 0; n < 8; n++) begin : g_ch
    logic [15:0] shadow;
    logic [15:0] active;
    logic        pwm_q;

    // Active values only reload at the wrap so a period never mixes two duties.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        shadow <= '0;
        active <= '0;
        pwm_q  <= 1'b0;
      end else begin
        if (write_strobe && in_range && (wr_idx == 3'(n))) shadow <= {data, data};
        if (pwm_wrap) active <= shadow;
        pwm_q <= (pwm_cnt < active);
      end
    end

    assign pwm[n] = pwm_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmx_pwm_dimmer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dmx_pwm_dimmer : directed bench for the DMX512 PWM dimmer (bit rate scaled down)
// Revision 1.0
// ============================================================================
module tb_dmx_pwm_dimmer;

  localparam int BIT = 16;
  localparam int BRK = 22 * BIT;
  localparam int W   = 17000;

  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic       dmx_in = 1'b1;
  logic [7:0] pwm0, data0, pwm1, data1;
  logic [8:0] ch0, ch1;
  logic       ws0, ws1;

  int checks   = 0;
  int failures = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic        ws0_d = 1'b0;
  logic        ws1_d = 1'b0;
  logic        counting_pre = 1'b0;
  logic [7:0]  pre_or = 8'h00;
  int          since_release = 0;

  logic [7:0] norm [8]  = '{8'h00, 8'h40, 8'h80, 8'hFF, 8'h01, 8'h10, 8'h20, 8'hFE};
  logic [7:0] upper [8] = '{8'h02, 8'h03, 8'h05, 8'h08, 8'h0C, 8'h20, 8'h30, 8'h00};
  int         exp0 [8]  = '{0, 16448, W, W, 257, 4112, 8224, W};
  int         exp1 [8]  = '{514, 771, 1285, 2056, 3084, 8224, 12336, 0};
  logic [7:0] pkt [16];

  always #5 clock = ~clock;

  dmx_pwm_dimmer #(.BIT_CLOCKS(BIT), .BREAK_CLOCKS(BRK), .BASE_CHANNEL(0)) u_dut0 (
    .clock(clock), .reset(reset), .dmx_in(dmx_in),
    .pwm(pwm0), .data(data0), .channel(ch0), .write_strobe(ws0)
  );

  dmx_pwm_dimmer #(.BIT_CLOCKS(BIT), .BREAK_CLOCKS(BRK), .BASE_CHANNEL(8)) u_dut1 (
    .clock(clock), .reset(reset), .dmx_in(dmx_in),
    .pwm(pwm1), .data(data1), .channel(ch1), .write_strobe(ws1)
  );

  // Strobe logger, strobe width check and pre-first-wrap pwm watcher.
  always @(negedge clock) begin
    if (ws0) begin
      q0.push_back({ch0, data0});
      checks++;
      if (ws0_d) begin
        failures++;
        $display("FAIL strobe_width dut0 high on two consecutive clocks, required 1 clock");
      end
    end
    if (ws1) q1.push_back({ch1, data1});
    ws0_d = ws0;
    ws1_d = ws1;
    if (counting_pre) begin
      if (pwm0[3] === 1'b1) counting_pre = 1'b0;
      else begin
        pre_or = pre_or | pwm0 | pwm1;
        since_release++;
      end
    end
  end

  task automatic wait_bits(input int n);
    repeat (n * BIT) @(negedge clock);
  endtask

  task automatic send_break(input int low_bits);
    dmx_in = 1'b0;
    wait_bits(low_bits);
    dmx_in = 1'b1;
    wait_bits(3);
  endtask

  task automatic send_slot(input logic [7:0] b, input logic stop_ok);
    dmx_in = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      dmx_in = b[i];
      wait_bits(1);
    end
    dmx_in = stop_ok;
    wait_bits(1);
    dmx_in = 1'b1;
    wait_bits(1);
  endtask

  task automatic send_packet(input logic [7:0] sc, input int n, input int bad_idx);
    send_break(25);
    send_slot(sc, 1'b1);
    for (int i = 0; i < n; i++) send_slot(pkt[i], (i != bad_idx));
    wait_bits(2);
  endtask

  task automatic test_reset();
    logic [7:0] acc_pwm = 8'h00;
    logic       acc_ws  = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (k % 13 == 0) dmx_in = ~dmx_in;
      acc_pwm = acc_pwm | pwm0 | pwm1;
      acc_ws  = acc_ws | ws0 | ws1;
    end
    checks++;
    if (acc_pwm !== 8'h00) begin failures++; $display("FAIL reset_pwm got %02h required 00", acc_pwm); end
    checks++;
    if (acc_ws !== 1'b0) begin failures++; $display("FAIL reset_strobe got %b required 0", acc_ws); end
    checks++;
    if (data0 !== 8'h00 || ch0 !== 9'd0) begin
      failures++; $display("FAIL reset_data_channel got data=%02h ch=%0d required 00/0", data0, ch0);
    end
    checks++;
    if (q0.size() !== 0) begin failures++; $display("FAIL reset_strobe_count got %0d required 0", q0.size()); end
    dmx_in = 1'b1;
    @(negedge clock);
    reset        = 1'b1;
    counting_pre = 1'b1;
  endtask

  task automatic test_normal();
    q0.delete(); q1.delete();
    for (int i = 0; i < 8; i++) pkt[i] = norm[i];
    send_packet(8'h00, 8, -1);
    checks++;
    if (q0.size() !== 8) begin failures++; $display("FAIL normal_count got %0d required 8", q0.size()); end
    for (int i = 0; i < 8 && i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== {9'(i), norm[i]}) begin
        failures++;
        $display("FAIL normal_entry[%0d] got ch=%0d data=%02h required ch=%0d data=%02h",
                 i, q0[i][16:8], q0[i][7:0], i, norm[i]);
      end
    end
    checks++;
    if (q1.size() !== 8) begin failures++; $display("FAIL normal_count_base8 got %0d required 8", q1.size()); end
    checks++;
    if (data0 !== 8'hFE || ch0 !== 9'd7) begin
      failures++; $display("FAIL normal_hold got data=%02h ch=%0d required FE/7", data0, ch0);
    end
  endtask

  task automatic test_start_code();
    q0.delete(); q1.delete();
    send_packet(8'hCC, 8, -1);
    checks++;
    if (q0.size() !== 0) begin failures++; $display("FAIL startcode_count got %0d required 0", q0.size()); end
    checks++;
    if (data0 !== 8'hFE || ch0 !== 9'd7) begin
      failures++; $display("FAIL startcode_hold got data=%02h ch=%0d required FE/7", data0, ch0);
    end
    checks++;
    if (pwm0 !== 8'h00) begin failures++; $display("FAIL startcode_pwm got %02h required 00", pwm0); end
  endtask

  task automatic test_framing();
    q0.delete(); q1.delete();
    send_packet(8'h00, 8, 3);
    checks++;
    if (q0.size() !== 3) begin failures++; $display("FAIL framing_count got %0d required 3", q0.size()); end
    for (int i = 0; i < 3 && i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== {9'(i), norm[i]}) begin
        failures++;
        $display("FAIL framing_entry[%0d] got ch=%0d data=%02h required ch=%0d data=%02h",
                 i, q0[i][16:8], q0[i][7:0], i, norm[i]);
      end
    end
  endtask

  task automatic test_short_pulse();
    logic [16:0] expq [5] = '{{9'd0, 8'h11}, {9'd1, 8'h22}, {9'd2, 8'h33}, {9'd0, 8'hA0}, {9'd1, 8'hA1}};
    q0.delete(); q1.delete();
    dmx_in = 1'b0;
    wait_bits(20);
    dmx_in = 1'b1;
    wait_bits(3);
    send_slot(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) send_slot(8'h55, 1'b1);
    wait_bits(2);
    checks++;
    if (q0.size() !== 0) begin failures++; $display("FAIL short_pulse_count got %0d required 0", q0.size()); end

    send_break(25);
    send_slot(8'h00, 1'b1);
    send_slot(8'h11, 1'b1);
    send_slot(8'h22, 1'b1);
    send_slot(8'h33, 1'b1);
    send_break(25);
    send_slot(8'h00, 1'b1);
    send_slot(8'hA0, 1'b1);
    send_slot(8'hA1, 1'b1);
    wait_bits(2);
    checks++;
    if (q0.size() !== 5) begin failures++; $display("FAIL midbreak_count got %0d required 5", q0.size()); end
    for (int i = 0; i < 5 && i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== expq[i]) begin
        failures++;
        $display("FAIL midbreak_entry[%0d] got ch=%0d data=%02h required ch=%0d data=%02h",
                 i, q0[i][16:8], q0[i][7:0], expq[i][16:8], expq[i][7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    q0.delete(); q1.delete();
    for (int i = 0; i < 8; i++) begin
      pkt[i]     = norm[i];
      pkt[i + 8] = upper[i];
    end
    send_packet(8'h00, 16, -1);
    checks++;
    if (q0.size() !== 16) begin failures++; $display("FAIL b2b_count got %0d required 16", q0.size()); end
    checks++;
    if (q1.size() !== 16) begin failures++; $display("FAIL b2b_count_base8 got %0d required 16", q1.size()); end
    for (int i = 0; i < 16 && i < q1.size(); i++) begin
      checks++;
      if (q1[i] !== {9'(i), pkt[i]}) begin
        failures++;
        $display("FAIL b2b_entry_base8[%0d] got ch=%0d data=%02h required ch=%0d data=%02h",
                 i, q1[i][16:8], q1[i][7:0], i, pkt[i]);
      end
    end
    checks++;
    if (data1 !== 8'h00 || ch1 !== 9'd15) begin
      failures++; $display("FAIL b2b_hold got data=%02h ch=%0d required 00/15", data1, ch1);
    end
  endtask

  task automatic test_pwm();
    int t = 0;
    int hi0 [8];
    int hi1 [8];
    while (pwm0[3] !== 1'b1 && t < 70000) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (pwm0[3] !== 1'b1) begin
      failures++; $display("FAIL pwm_first_wrap timeout got no pwm[3] rise required rise within 70000 clocks");
      return;
    end
    checks++;
    if (pre_or !== 8'h00) begin failures++; $display("FAIL pwm_low_first_period got %02h required 00", pre_or); end
    checks++;
    if (since_release < 65530 || since_release > 65545) begin
      failures++; $display("FAIL pwm_wrap_time got %0d required 65530..65545", since_release);
    end
    for (int n = 0; n < 8; n++) begin
      hi0[n] = 0;
      hi1[n] = 0;
    end
    repeat (W) begin
      for (int n = 0; n < 8; n++) begin
        hi0[n] += int'(pwm0[n]);
        hi1[n] += int'(pwm1[n]);
      end
      @(negedge clock);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (hi0[n] !== exp0[n]) begin
        failures++; $display("FAIL pwm_high_base0[%0d] got %0d required %0d", n, hi0[n], exp0[n]);
      end
      checks++;
      if (hi1[n] !== exp1[n]) begin
        failures++; $display("FAIL pwm_high_base8[%0d] got %0d required %0d", n, hi1[n], exp1[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_start_code();
    test_framing();
    test_short_pulse();
    test_back_to_back();
    test_pwm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
